id_ex_stage_reg: RTL

- Parametrised, elastic ID/EX pipeline register that replaces the fixed always-load ID/EX latch.
- Carries WB/M/EX control plus operand, immediate and register-specifier fields from decode to execute.
- Adds a valid/ready handshake with a one-entry skid buffer, flush (bubble insertion) from the hazard unit, and a saturating squash counter for performance debug.

---
 rtl/id_ex_stage_reg_if.sv | 52 +++++
 rtl/id_ex_stage_reg.sv | 114 +++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg_if.sv
// Bundle of the decode-to-execute pipeline handshake and payload.
// The stage uses the slave view. The decode/execute environment uses the master view.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int EX_W   = 5,
  parameter int CNT_W  = 16
);
  // Upstream (decode) side
  logic              id_valid;
  logic              id_ready;
  logic              flush;
  logic [1:0]        id_wb;
  logic [1:0]        id_m;
  logic [EX_W-1:0]   id_ex;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;

  // Downstream (execute) side
  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_wb;
  logic [1:0]        ex_m;
  logic [EX_W-1:0]   ex_ex;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;

  // Performance debug
  logic [CNT_W-1:0]  squash_cnt;

  modport master (
    output id_valid, flush, id_wb, id_m, id_ex, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, ex_ready,
    input  id_ready, ex_valid, ex_wb, ex_m, ex_ex, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, squash_cnt
  );

  modport slave (
    input  id_valid, flush, id_wb, id_m, id_ex, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, ex_ready,
    output id_ready, ex_valid, ex_wb, ex_m, ex_ex, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, squash_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// Elastic ID/EX pipeline register.
// A main entry drives execute, and a one-entry skid buffer absorbs a beat while execute stalls.
// A hazard-unit flush kills both entries and drops any incoming beat.
// A saturating counter records how many flushes killed live work.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int EX_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_stage_reg_if.slave   bus
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [1:0]        m;
    logic [EX_W-1:0]   ex;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } payload_t;

  logic             r_m_valid;
  logic             r_s_valid;
  payload_t         r_m_pay;
  payload_t         r_s_pay;
  logic [CNT_W-1:0] r_squash_cnt;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_m_free;
  payload_t         w_in_pay;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready comes only from the skid flop, so ex_ready never reaches id_ready combinationally
  assign bus.id_ready = !r_s_valid;
  assign w_in_fire    = bus.id_valid & !r_s_valid;
  assign w_out_fire   = r_m_valid & bus.ex_ready;
  assign w_m_free     = w_out_fire | !r_m_valid;

  assign w_in_pay = '{wb:  bus.id_wb,  m:   bus.id_m,   ex:  bus.id_ex,
                      rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm,
                      rs:  bus.id_rs,  rt:  bus.id_rt,  rd:  bus.id_rd};

  // Occupancy of the main and skid entries; flush wins over every transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (bus.flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_m_free && r_s_valid) begin
      r_m_valid <= 1'b1;
      r_s_valid <= 1'b0;
    end else if (w_m_free && w_in_fire) begin
      r_m_valid <= 1'b1;
    end else if (w_m_free) begin
      r_m_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s_valid <= 1'b1;
    end
  end

  // Payload movement mirroring the occupancy rules; flush only clears main control fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_pay <= '0;
      r_s_pay <= '0;
    end else if (bus.flush) begin
      r_m_pay.wb <= '0;
      r_m_pay.m  <= '0;
      r_m_pay.ex <= '0;
    end else if (w_m_free && r_s_valid) begin
      r_m_pay <= r_s_pay;
    end else if (w_m_free && w_in_fire) begin
      r_m_pay <= w_in_pay;
    end else if (w_in_fire) begin
      r_s_pay <= w_in_pay;
    end
  end

  // Count flushes that actually killed a valid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_squash_cnt <= '0;
    end else if (bus.flush && (r_m_valid || r_s_valid)) begin
      r_squash_cnt <= sat_inc(r_squash_cnt);
    end
  end

  // An empty stage always presents a NOP on the control fields
  assign bus.ex_valid   = r_m_valid;
  assign bus.ex_wb      = r_m_valid ? r_m_pay.wb : 2'b00;
  assign bus.ex_m       = r_m_valid ? r_m_pay.m  : 2'b00;
  assign bus.ex_ex      = r_m_valid ? r_m_pay.ex : '0;
  assign bus.ex_rd1     = r_m_pay.rd1;
  assign bus.ex_rd2     = r_m_pay.rd2;
  assign bus.ex_imm     = r_m_pay.imm;
  assign bus.ex_rs      = r_m_pay.rs;
  assign bus.ex_rt      = r_m_pay.rt;
  assign bus.ex_rd      = r_m_pay.rd;
  assign bus.squash_cnt = r_squash_cnt;

endmodule
